// File: rtl/regfile_pkg.sv
// Shared constants and the write-request record for the register-file
// write arbiter and its holding buffers.
package regfile_pkg;

    localparam int RF_WIDTH    = 4;
    localparam int RF_AW       = 3;
    localparam int RF_DEPTH    = 1 << RF_AW;
    localparam int RF_ZERO_REG = 0;

    // One register-file write as handed over by a requester.
    typedef struct packed {
        logic [RF_AW-1:0]    addr;
        logic [RF_WIDTH-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/wr_holding_buf.sv
// One-entry holding buffer for a writeback requester. Accepts a write when
// empty or when its current entry is being retired on the same edge.
module wr_holding_buf
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int AW    = RF_AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_retire,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic             o_ready,
    output logic [AW-1:0]    o_addr,
    output logic [WIDTH-1:0] o_data
);

    logic             r_valid;
    logic [AW-1:0]    r_addr;
    logic [WIDTH-1:0] r_data;

    // Occupancy flag: a load wins over a retire so retire+refill keeps it set.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (i_retire) begin
            r_valid <= 1'b0;
        end
    end

    // Payload capture on handshake.
    always_ff @(posedge clk) begin
        // NOTE: the payload is deliberately left out of reset; it is only
        // observed while r_valid is set, so resetting it buys nothing.
        if (i_load) begin
            r_addr <= i_addr;
            r_data <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_ready = !r_valid || i_retire;
    assign o_addr  = r_addr;
    assign o_data  = r_data;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between two writeback
// requesters. Each port feeds a one-entry holding buffer; one buffered write
// is retired per cycle onto registered rf_* outputs. Writes to register 0
// are retired without a write strobe and counted in drop_cnt.
// Build option: define WRARB_FIXED_PRIO_EN to make port 0 always win
// contention instead of round-robin.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int WIDTH = RF_WIDTH,
    parameter int AW    = RF_AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [AW-1:0]        req0_addr,
    input  logic [WIDTH-1:0]     req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [AW-1:0]        req1_addr,
    input  logic [WIDTH-1:0]     req1_data,
    output logic                 req1_ready,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [WIDTH-1:0]     rf_wdata,
    output logic [(1<<AW)-1:0]   pend_mask,
    output logic [7:0]           drop_cnt
);

    localparam int DEPTH = 1 << AW;

    logic             w_v0, w_v1;
    logic [AW-1:0]    w_addr0, w_addr1;
    logic [WIDTH-1:0] w_data0, w_data1;
    logic             w_grant0, w_grant1;
    logic             w_any_grant;
    logic [AW-1:0]    w_win_addr;
    logic [WIDTH-1:0] w_win_data;
    logic [DEPTH-1:0] w_pend;

    logic             r_we;
    logic [AW-1:0]    r_waddr;
    logic [WIDTH-1:0] r_wdata;
    logic [7:0]       r_drop_cnt;

    wr_holding_buf #(.WIDTH(WIDTH), .AW(AW)) u_buf0 (
        .clk      (clk),
        .rst      (rst),
        .i_load   (req0_valid && req0_ready),
        .i_retire (w_grant0),
        .i_addr   (req0_addr),
        .i_data   (req0_data),
        .o_valid  (w_v0),
        .o_ready  (req0_ready),
        .o_addr   (w_addr0),
        .o_data   (w_data0)
    );

    wr_holding_buf #(.WIDTH(WIDTH), .AW(AW)) u_buf1 (
        .clk      (clk),
        .rst      (rst),
        .i_load   (req1_valid && req1_ready),
        .i_retire (w_grant1),
        .i_addr   (req1_addr),
        .i_data   (req1_data),
        .o_valid  (w_v1),
        .o_ready  (req1_ready),
        .o_addr   (w_addr1),
        .o_data   (w_data1)
    );

`ifdef WRARB_FIXED_PRIO_EN
    // Fixed priority: port 0 always wins contention.
    assign w_grant0 = w_v0;
    assign w_grant1 = w_v1 && !w_v0;
`else
    logic r_rr_last;

    // Round-robin: under contention the port that did not win last goes.
    assign w_grant0 = w_v0 && (!w_v1 || r_rr_last);
    assign w_grant1 = w_v1 && (!w_v0 || !r_rr_last);

    // Remember the most recent winner; reset favours port 0 first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last <= 1'b1;
        end else if (w_grant0 || w_grant1) begin
            r_rr_last <= w_grant1;
        end
    end
`endif

    assign w_any_grant = w_grant0 || w_grant1;
    assign w_win_addr  = w_grant1 ? w_addr1 : w_addr0;
    assign w_win_data  = w_grant1 ? w_data1 : w_data0;

    // Register the winning write; register-0 writes are retired but dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
            r_drop_cnt <= '0;
        end else if (w_any_grant && (w_win_addr != AW'(RF_ZERO_REG))) begin
            r_we    <= 1'b1;
            r_waddr <= w_win_addr;
            r_wdata <= w_win_data;
        end else begin
            r_we <= 1'b0;
            if (w_any_grant && r_drop_cnt != 8'hFF) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // Pending-address mask from buffered writes; register 0 never pends.
    always_comb begin
        // NOTE: default first so every path assigns w_pend and no latch forms.
        w_pend = '0;
        if (w_v0) w_pend[w_addr0] = 1'b1;
        if (w_v1) w_pend[w_addr1] = 1'b1;
        w_pend[RF_ZERO_REG] = 1'b0;
    end

    assign pend_mask = w_pend;
    assign rf_we     = r_we;
    assign rf_waddr  = r_waddr;
    assign rf_wdata  = r_wdata;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter. Drivers push the expected
// register-file writes into a scoreboard queue in grant order; a monitor
// pops and compares whenever rf_we is seen high.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    logic                req0_valid, req1_valid;
    logic [RF_AW-1:0]    req0_addr, req1_addr;
    logic [RF_WIDTH-1:0] req0_data, req1_data;
    logic                req0_ready, req1_ready;
    logic                rf_we;
    logic [RF_AW-1:0]    rf_waddr;
    logic [RF_WIDTH-1:0] rf_wdata;
    logic [RF_DEPTH-1:0] pend_mask;
    logic [7:0]          drop_cnt;

    int total = 0;
    int bad   = 0;
    wr_req_t sb[$];

    regfile_write_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .pend_mask  (pend_mask),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic [RF_AW-1:0] a, input logic [RF_WIDTH-1:0] d);
        wr_req_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    // Monitor: every cycle with rf_we high must match the oldest expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && rf_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_write", {25'd0, rf_waddr, rf_wdata}, 32'hFFFF_FFFF);
            end else begin
                wr_req_t e;
                e = sb.pop_front();
                check("wr_addr", 32'(rf_waddr), 32'(e.addr));
                check("wr_data", 32'(rf_wdata), 32'(e.data));
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Hand one write to port 0; reports how many edges it took.
    task automatic send0(input logic [RF_AW-1:0] a, input logic [RF_WIDTH-1:0] d, output int edges);
        logic acc;
        edges = 0;
        req0_valid = 1'b1;
        req0_addr  = a;
        req0_data  = d;
        do begin
            @(negedge clk);
            acc = req0_ready;
            @(posedge clk);
            #1;
            edges++;
        end while (!acc && edges < 50);
        if (!acc) check("send0_timeout", 32'(acc), 32'd1);
        req0_valid = 1'b0;
    endtask

    task automatic send1(input logic [RF_AW-1:0] a, input logic [RF_WIDTH-1:0] d, output int edges);
        logic acc;
        edges = 0;
        req1_valid = 1'b1;
        req1_addr  = a;
        req1_data  = d;
        do begin
            @(negedge clk);
            acc = req1_ready;
            @(posedge clk);
            #1;
            edges++;
        end while (!acc && edges < 50);
        if (!acc) check("send1_timeout", 32'(acc), 32'd1);
        req1_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [5:0] pat;

        rst = 1'b1;
        req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
        req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
        cycle();
        cycle();
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_waddr", 32'(rf_waddr), 32'd0);
        check("rst_wdata", 32'(rf_wdata), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_pend", 32'(pend_mask), 32'd0);
        check("rst_ready0", 32'(req0_ready), 32'd1);
        check("rst_ready1", 32'(req1_ready), 32'd1);
        cycle();

        // Single write, two-cycle latency.
        expect_wr(3'd3, 4'hA);
        send0(3'd3, 4'hA, n);
        @(negedge clk);
        check("single_pend", 32'(pend_mask), 32'h08);
        check("single_we_early", 32'(rf_we), 32'd0);
        cycle();
        @(negedge clk);
        check("single_we", 32'(rf_we), 32'd1);
        check("single_pend_clr", 32'(pend_mask), 32'h00);
        cycle();
        @(negedge clk);
        check("single_we_off", 32'(rf_we), 32'd0);
        cycle();

        // Register-0 write is accepted, retired and counted, never written.
        send1(3'd0, 4'hF, n);
        check("zero_accept_edges", 32'(n), 32'd1);
        @(negedge clk);
        check("zero_pend", 32'(pend_mask), 32'h00);
        cycle();
        @(negedge clk);
        check("zero_we", 32'(rf_we), 32'd0);
        check("zero_drop", 32'(drop_cnt), 32'd1);
        repeat (2) cycle();

        // Contention: both ports stream simultaneously.
`ifdef WRARB_FIXED_PRIO_EN
        expect_wr(3'd1, 4'h9); expect_wr(3'd2, 4'hA); expect_wr(3'd3, 4'hB);
        expect_wr(3'd4, 4'hC); expect_wr(3'd5, 4'h3); expect_wr(3'd6, 4'h4);
        expect_wr(3'd7, 4'h5);
`else
        expect_wr(3'd1, 4'h9); expect_wr(3'd5, 4'h3); expect_wr(3'd2, 4'hA);
        expect_wr(3'd6, 4'h4); expect_wr(3'd3, 4'hB); expect_wr(3'd7, 4'h5);
        expect_wr(3'd4, 4'hC);
`endif
        pat = '0;
        fork
            begin
                int e0;
                send0(3'd1, 4'h9, e0);
                send0(3'd2, 4'hA, e0);
                send0(3'd3, 4'hB, e0);
                send0(3'd4, 4'hC, e0);
            end
            begin
                int e1;
                send1(3'd5, 4'h3, e1);
                send1(3'd6, 4'h4, e1);
                send1(3'd7, 4'h5, e1);
            end
        join
        repeat (4) cycle();
        check("contention_drained", 32'(sb.size()), 32'd0);

        // Uncontested stream on port 0: full rate, rf_we high three cycles.
        expect_wr(3'd2, 4'h1); expect_wr(3'd4, 4'h2); expect_wr(3'd6, 4'h3);
        fork
            begin
                int e2;
                send0(3'd2, 4'h1, e2);
                check("stream_wait0", 32'(e2), 32'd1);
                send0(3'd4, 4'h2, e2);
                check("stream_wait1", 32'(e2), 32'd1);
                send0(3'd6, 4'h3, e2);
                check("stream_wait2", 32'(e2), 32'd1);
            end
            begin
                repeat (6) begin
                    @(negedge clk);
                    pat = {pat[4:0], rf_we};
                end
            end
        join
        check("stream_we_pattern", 32'(pat), 32'b001110);
        repeat (3) cycle();

        // Port 1 wins alone, so port 0 wins the next contention in both modes.
        expect_wr(3'd2, 4'h1);
        send1(3'd2, 4'h1, n);
        repeat (3) cycle();

        // Stall: both buffers fill on one edge, port 1 waits for its grant.
        expect_wr(3'd4, 4'h6); expect_wr(3'd6, 4'h7);
        req0_valid = 1'b1; req0_addr = 3'd4; req0_data = 4'h6;
        req1_valid = 1'b1; req1_addr = 3'd6; req1_data = 4'h7;
        cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        check("stall_pend_both", 32'(pend_mask), 32'h50);
        check("stall_ready1_low", 32'(req1_ready), 32'd0);
        check("stall_ready0_grant", 32'(req0_ready), 32'd1);
        cycle();
        @(negedge clk);
        check("stall_ready1_grant", 32'(req1_ready), 32'd1);
        check("stall_pend_one", 32'(pend_mask), 32'h40);
        repeat (3) cycle();

        // Reset with both buffers full: the buffered writes must vanish.
        req0_valid = 1'b1; req0_addr = 3'd5; req0_data = 4'h7;
        req1_valid = 1'b1; req1_addr = 3'd6; req1_data = 4'h8;
        cycle();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_pend_full", 32'(pend_mask), 32'h60);
        cycle();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_we", 32'(rf_we), 32'd0);
        check("midrst_pend", 32'(pend_mask), 32'h00);
        check("midrst_drop", 32'(drop_cnt), 32'd0);
        check("midrst_ready0", 32'(req0_ready), 32'd1);
        check("midrst_ready1", 32'(req1_ready), 32'd1);
        repeat (5) cycle();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
